sampletest_hs: RTL and testbench
================================

SAMPLETEST_HS -- requirements
Module: sampletest_hs

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Parameters (name, default, meaning), one per line:
- SIGFIG, 24, bits in position and color.
- RADIX, 10, fraction bits.
- AXIS, 3, axes per vertex.
- COLORS, 3, color channels.
- PIPE_DEPTH, 2, register stages from R16 to R18 (legal range 1..8).
- CNT_W, 32, width of the performance counters.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- tri_R16S, in, 3xAXISxSIGFIG signed, triangle vertices.
- color_R16U, in, COLORSxSIGFIG, triangle color.
- sample_R16S, in, 2xSIGFIG signed, sample location.
- validSamp_R16H, in, 1, input beat valid.
- readySamp_R16H, out, 1, block accepts the beat this cycle.
- cull_mode_R16U, in, 2, per-beat cull mode: 00 cull back, 01 cull front, 10 no cull, 11 reserved (treated as 10).
- hit_R18S, out, AXISxSIGFIG signed, hit location.
- color_R18U, out, COLORSxSIGFIG, color.
- hit_valid_R18H, out, 1, output beat valid.
- hit_ready_R18H, in, 1, downstream accepts the output beat.
- samp_cnt_R18U, out, CNT_W, count of accepted samples.
- hit_cnt_R18U, out, CNT_W, count of emitted hits.

Function
REQ-004 A beat SHALL be accepted when validSamp_R16H && readySamp_R16H.
REQ-005 Edge deltas SHALL be vertex minus sample, computed at SIGFIG+1 bits signed. Each edge distance x_a*y_b - x_b*y_a SHALL be computed at 2*SIGFIG+3 bits signed, with no truncation.
REQ-006 Edges SHALL be e0=(v0,v1), e1=(v1,v2), e2=(v2,v0).
REQ-007 Clockwise-inside SHALL be d0<=0 && d1<0 && d2<=0.
REQ-008 Counterclockwise-inside SHALL be d0>=0 && d1>0 && d2>=0.
REQ-009 Hit rule by mode:
- mode 00: hit = CW.
- mode 01: hit = CCW.
- mode 10/11: hit = CW || CCW.
REQ-010 A degenerate triangle (all three distances zero) SHALL be a miss in every mode.
REQ-011 hit_R18S[1:0] SHALL carry the unjittered sample, and hit_R18S[2] SHALL carry tri_R16S[0][2].
REQ-012 The pipeline SHALL have PIPE_DEPTH stages, each with a stage-valid bit. With no stall, an accepted hit SHALL appear at the output exactly PIPE_DEPTH cycles after acceptance.
REQ-013 Misses SHALL be dropped: a missed beat advances as a bubble and never asserts hit_valid_R18H.
REQ-014 A stage SHALL advance when it is empty, or when the next stage advances, or (for the last stage) when hit_ready_R18H is high. Bubbles SHALL collapse, so a stall with empty stages does not block input.
REQ-015 readySamp_R16H SHALL equal the advance condition of stage 0, and is combinational from hit_ready_R18H.
REQ-016 While hit_valid_R18H && !hit_ready_R18H, all R18 outputs SHALL hold stable.
REQ-017 samp_cnt_R18U SHALL increment on each accepted beat.
REQ-018 hit_cnt_R18U SHALL increment on each output handshake.
REQ-019 Both counters SHALL saturate at all-ones and not wrap.
REQ-020 Simultaneous input acceptance and output handshake in one cycle SHALL be supported with no loss or duplication.

Reset
REQ-021 On rst, all stage-valid bits, hit_valid_R18H and both counters SHALL clear to 0 on the next clock edge. Data registers need no reset.
REQ-022 Beats in flight when rst is asserted mid-operation SHALL be discarded. readySamp_R16H SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-023 The cull-mode enum and edge/distance width constants SHALL live in the shared rasterizer package.
REQ-024 Edge evaluation and the hit decision SHALL be one combinational sub-module, edge_eval. The handshake pipeline SHALL be in sampletest_hs.

Verification
(Defaults apply; RADIX 10 means 1.0 = 1024.)
REQ-025 Mode 00 CW hit:
- Stimulus: v=(0,0),(0,4096),(4096,0); sample=(1024,1024).
- Required: one output beat after 2 cycles, hit=(1024,1024,z0); hit_cnt=1.
REQ-026 Cull modes on the REQ-025 triangle with v1 and v2 swapped:
- mode 00: no output; samp_cnt=1, hit_cnt=0.
- mode 01: hit.
- mode 10: hit.
REQ-027 Edge tie, same triangle as REQ-025:
- Sample (0,2048) lies on e0: hit in mode 00.
- Sample (2048,2048) lies on e1: miss.
- Degenerate triangle with all vertices at (0,0): miss in all modes.
REQ-028 Backpressure:
- Stimulus: 10 back-to-back hits with hit_ready_R18H low for cycles 3-7.
- Required: outputs hold stable while stalled, readySamp_R16H drops once the pipe is full, all 10 hits arrive in order, hit_cnt=10.
REQ-029 Bubble collapse with mid-operation reset:
- Stimulus: alternating hit/miss with ready low; then assert rst with 2 beats in flight.
- Required: misses never block input; after reset, no stale output and counters are 0.
REQ-030 Counter saturation:
- Stimulus: counters at all-ones minus 1, then 3 hits.
- Required: both counters end at all-ones.

Source files
------------

// File: rtl/sampletest_hs_pkg.sv
// Shared rasterizer types and width constants for the sample tester.
// Edge deltas carry one guard bit; edge distances carry three.
package sampletest_hs_pkg;

    typedef enum logic [1:0] {
        CULL_BACK  = 2'b00,
        CULL_FRONT = 2'b01,
        CULL_NONE  = 2'b10,
        CULL_RSVD  = 2'b11
    } cull_mode_e;

    localparam int EDGE_XW = 1;
    localparam int DIST_XW = 3;

    function automatic int edge_w(input int sigfig);
        return sigfig + EDGE_XW;
    endfunction

    function automatic int dist_w(input int sigfig);
        return 2 * sigfig + DIST_XW;
    endfunction

endpackage

// File: rtl/sampletest_hs_if.sv
// Sample-in / hit-out bundle for the sample tester.
// The master drives samples and consumes hits; the slave is the tester.
interface sampletest_hs_if
    import sampletest_hs_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int CNT_W  = 32
);
    logic [2:0][AXIS-1:0][SIGFIG-1:0] tri_R16S;
    logic [COLORS-1:0][SIGFIG-1:0]    color_R16U;
    logic [1:0][SIGFIG-1:0]           sample_R16S;
    logic                             validSamp_R16H;
    logic                             readySamp_R16H;
    cull_mode_e                       cull_mode_R16U;
    logic [AXIS-1:0][SIGFIG-1:0]      hit_R18S;
    logic [COLORS-1:0][SIGFIG-1:0]    color_R18U;
    logic                             hit_valid_R18H;
    logic                             hit_ready_R18H;
    logic [CNT_W-1:0]                 samp_cnt_R18U;
    logic [CNT_W-1:0]                 hit_cnt_R18U;

    modport master (
        output tri_R16S, color_R16U, sample_R16S,
        output validSamp_R16H, cull_mode_R16U, hit_ready_R18H,
        input  readySamp_R16H, hit_R18S, color_R18U,
        input  hit_valid_R18H, samp_cnt_R18U, hit_cnt_R18U
    );

    modport slave (
        input  tri_R16S, color_R16U, sample_R16S,
        input  validSamp_R16H, cull_mode_R16U, hit_ready_R18H,
        output readySamp_R16H, hit_R18S, color_R18U,
        output hit_valid_R18H, samp_cnt_R18U, hit_cnt_R18U
    );

endinterface

// File: rtl/sampletest_hs_edge_eval.sv
// Combinational edge-function evaluation and cull-mode hit decision.
// Only the x/y components of each vertex take part in the test.
module edge_eval
    import sampletest_hs_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int AXIS   = 3
) (
    input  logic [2:0][AXIS-1:0][SIGFIG-1:0] i_tri,
    input  logic [1:0][SIGFIG-1:0]           i_sample,
    input  cull_mode_e                       i_mode,
    output logic                             o_hit
);
    localparam int EW = edge_w(SIGFIG);
    localparam int DW = dist_w(SIGFIG);

    logic signed [EW-1:0] w_ex [3];
    logic signed [EW-1:0] w_ey [3];
    logic signed [DW-1:0] w_d  [3];
    logic [2:0] w_neg;
    logic [2:0] w_zero;
    logic w_cw;
    logic w_ccw;
    logic w_degen;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_ex[i] = EW'($signed(i_tri[i][0])) - EW'($signed(i_sample[0]));
            w_ey[i] = EW'($signed(i_tri[i][1])) - EW'($signed(i_sample[1]));
        end
        // Edge i runs from vertex i to vertex (i+1) mod 3
        for (int i = 0; i < 3; i++) begin
            w_d[i] = DW'(w_ex[i]) * DW'(w_ey[(i+1)%3])
                   - DW'(w_ex[(i+1)%3]) * DW'(w_ey[i]);
            w_neg[i]  = w_d[i][DW-1];
            w_zero[i] = (w_d[i] == '0);
        end
    end

    assign w_cw = (w_neg[0] | w_zero[0]) & w_neg[1]
                & (w_neg[2] | w_zero[2]);
    assign w_ccw = ~w_neg[0] & ~w_neg[1] & ~w_zero[1] & ~w_neg[2];
    assign w_degen = &w_zero;

    always_comb begin
        o_hit = 1'b0;
        unique case (i_mode)
            CULL_BACK:            o_hit = w_cw;
            CULL_FRONT:           o_hit = w_ccw;
            CULL_NONE, CULL_RSVD: o_hit = w_cw | w_ccw;
        endcase
        if (w_degen) o_hit = 1'b0;
    end

endmodule

// File: rtl/sampletest_hs.sv
// Sample-vs-triangle tester with an elastic valid/ready pipeline.
// Misses enter as bubbles; bubbles collapse under output backpressure.
module sampletest_hs
    import sampletest_hs_pkg::*;
#(
    parameter int SIGFIG     = 24,
    parameter int RADIX      = 10,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    sampletest_hs_if.slave  bus
);
    typedef logic [AXIS-1:0][SIGFIG-1:0]   hit_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0] col_t;

    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8 || RADIX >= SIGFIG) begin : g_bad_param
        $error("sampletest_hs: illegal parameter set");
    end

    logic                  w_hit;
    hit_t                  w_hit_in;
    logic [PIPE_DEPTH-1:0] w_adv;
    logic                  w_acc;
    logic                  w_out;
    logic [PIPE_DEPTH-1:0] r_vld;
    hit_t                  r_hit [PIPE_DEPTH];
    col_t                  r_col [PIPE_DEPTH];
    logic [CNT_W-1:0]      r_samp_cnt;
    logic [CNT_W-1:0]      r_hit_cnt;

    edge_eval #(
        .SIGFIG (SIGFIG),
        .AXIS   (AXIS)
    ) u_edge_eval (
        .i_tri    (bus.tri_R16S),
        .i_sample (bus.sample_R16S),
        .i_mode   (bus.cull_mode_R16U),
        .o_hit    (w_hit)
    );

    always_comb begin
        w_hit_in    = '0;
        w_hit_in[0] = bus.sample_R16S[0];
        w_hit_in[1] = bus.sample_R16S[1];
        w_hit_in[2] = bus.tri_R16S[0][2];
    end

    // A stage moves if any stage at or after it is empty, or the sink is ready
    always_comb begin : p_adv
        logic v_full;
        v_full = 1'b1;
        w_adv  = '0;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            v_full   = v_full & r_vld[i];
            w_adv[i] = ~v_full | bus.hit_ready_R18H;
        end
    end

    assign w_acc = bus.validSamp_R16H & w_adv[0];
    assign w_out = r_vld[PIPE_DEPTH-1] & bus.hit_ready_R18H;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            if (w_adv[0]) r_vld[0] <= w_acc & w_hit;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                if (w_adv[i]) r_vld[i] <= r_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv[0] && w_acc) begin
            r_hit[0] <= w_hit_in;
            r_col[0] <= bus.color_R16U;
        end
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            if (w_adv[i] && r_vld[i-1]) begin
                r_hit[i] <= r_hit[i-1];
                r_col[i] <= r_col[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_samp_cnt <= '0;
            r_hit_cnt  <= '0;
        end else begin
            if (w_acc && !(&r_samp_cnt)) r_samp_cnt <= r_samp_cnt + 1'b1;
            if (w_out && !(&r_hit_cnt))  r_hit_cnt  <= r_hit_cnt + 1'b1;
        end
    end

    assign bus.readySamp_R16H = w_adv[0];
    assign bus.hit_valid_R18H = r_vld[PIPE_DEPTH-1];
    assign bus.hit_R18S       = r_hit[PIPE_DEPTH-1];
    assign bus.color_R18U     = r_col[PIPE_DEPTH-1];
    assign bus.samp_cnt_R18U  = r_samp_cnt;
    assign bus.hit_cnt_R18U   = r_hit_cnt;

endmodule

// File: tb/tb_sampletest_hs.sv
// Randomized and directed bench for sampletest_hs with a queue scoreboard.
module tb_sampletest_hs;
    import sampletest_hs_pkg::*;

    localparam int SF = 24;
    localparam int AX = 3;
    localparam int CL = 3;
    localparam int PD = 2;
    localparam int CW = 4;

    typedef logic [2:0][AX-1:0][SF-1:0] tri_t;
    typedef logic [1:0][SF-1:0]         samp_t;
    typedef logic [AX-1:0][SF-1:0]      vec_t;
    typedef logic [CL-1:0][SF-1:0]      col_t;
    typedef struct {
        vec_t h;
        col_t c;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sampletest_hs_if #(.SIGFIG(SF), .AXIS(AX), .COLORS(CL), .CNT_W(CW)) bus ();

    sampletest_hs #(
        .SIGFIG(SF), .RADIX(10), .AXIS(AX), .COLORS(CL),
        .PIPE_DEPTH(PD), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_test = 0;
    int          n_fail = 0;
    bit          mon_en = 0;
    bit          saw_stall = 0;
    bit          rnd_done = 0;
    beat_t       q[$];
    beat_t       mb;
    logic [CW-1:0] m_scnt = '0;
    logic [CW-1:0] m_hcnt = '0;
    bit          prev_stall = 0;
    vec_t        prev_h;
    col_t        prev_c;

    // Reference: signed area of each edge against the sample, plain integers
    function automatic bit model_hit(input tri_t t, input samp_t s, input int m);
        longint x[3];
        longint y[3];
        longint d[3];
        bit cw;
        bit ccw;
        for (int i = 0; i < 3; i++) begin
            x[i] = longint'($signed(t[i][0])) - longint'($signed(s[0]));
            y[i] = longint'($signed(t[i][1])) - longint'($signed(s[1]));
        end
        for (int i = 0; i < 3; i++)
            d[i] = x[i] * y[(i+1)%3] - x[(i+1)%3] * y[i];
        if (d[0] == 0 && d[1] == 0 && d[2] == 0) return 1'b0;
        cw  = (d[0] <= 0) && (d[1] < 0) && (d[2] <= 0);
        ccw = (d[0] >= 0) && (d[1] > 0) && (d[2] >= 0);
        if (m == 0) return cw;
        if (m == 1) return ccw;
        return cw || ccw;
    endfunction

    function automatic tri_t mk_tri(input int x0, y0, z0, x1, y1, x2, y2);
        tri_t t;
        t = '0;
        t[0][0] = SF'(x0); t[0][1] = SF'(y0); t[0][2] = SF'(z0);
        t[1][0] = SF'(x1); t[1][1] = SF'(y1); t[1][2] = SF'(555);
        t[2][0] = SF'(x2); t[2][1] = SF'(y2); t[2][2] = SF'(999);
        return t;
    endfunction

    function automatic samp_t mk_samp(input int x, input int y);
        samp_t s;
        s[0] = SF'(x);
        s[1] = SF'(y);
        return s;
    endfunction

    function automatic col_t rcol();
        col_t c;
        for (int k = 0; k < CL; k++) c[k] = SF'($urandom);
        return c;
    endfunction

    function automatic int rcoord();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return int'($urandom_range(0, 32'hFFFFFF)) - 8388608;
        if (r < 3) return int'($urandom_range(0, 8)) - 4;
        return int'($urandom_range(0, 6000)) - 3000;
    endfunction

    // Scoreboard: predicts counters and output beats from observed handshakes
    always @(negedge clk) begin
        if (mon_en) begin
            n_test++;
            if (bus.samp_cnt_R18U !== m_scnt) begin
                n_fail++;
                $display("FAIL samp_cnt got=%0d exp=%0d", bus.samp_cnt_R18U, m_scnt);
            end
            n_test++;
            if (bus.hit_cnt_R18U !== m_hcnt) begin
                n_fail++;
                $display("FAIL hit_cnt got=%0d exp=%0d", bus.hit_cnt_R18U, m_hcnt);
            end
            if (prev_stall) begin
                n_test++;
                if (bus.hit_valid_R18H !== 1'b1 || bus.hit_R18S !== prev_h
                    || bus.color_R18U !== prev_c) begin
                    n_fail++;
                    $display("FAIL stall_hold got=%h exp=%h", bus.hit_R18S, prev_h);
                end
            end
            if (rst) begin
                q.delete();
                m_scnt = '0;
                m_hcnt = '0;
                prev_stall = 0;
            end else begin
                if (bus.validSamp_R16H && bus.readySamp_R16H) begin
                    if (m_scnt != '1) m_scnt = m_scnt + 1'b1;
                    if (model_hit(bus.tri_R16S, bus.sample_R16S,
                                  int'(bus.cull_mode_R16U))) begin
                        mb.h    = '0;
                        mb.h[0] = bus.sample_R16S[0];
                        mb.h[1] = bus.sample_R16S[1];
                        mb.h[2] = bus.tri_R16S[0][2];
                        mb.c    = bus.color_R16U;
                        q.push_back(mb);
                    end
                end
                if (bus.hit_valid_R18H && bus.hit_ready_R18H) begin
                    n_test++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_hit got=%h exp=none", bus.hit_R18S);
                    end else begin
                        mb = q.pop_front();
                        if (bus.hit_R18S !== mb.h || bus.color_R18U !== mb.c) begin
                            n_fail++;
                            $display("FAIL hit_data got=%h/%h exp=%h/%h",
                                     bus.hit_R18S, bus.color_R18U, mb.h, mb.c);
                        end
                    end
                    if (m_hcnt != '1) m_hcnt = m_hcnt + 1'b1;
                end
                prev_stall = bus.hit_valid_R18H && !bus.hit_ready_R18H;
                prev_h = bus.hit_R18S;
                prev_c = bus.color_R18U;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input tri_t t, input samp_t s, input col_t c, input int m);
        int n;
        logic [1:0] mm;
        n  = 0;
        mm = m[1:0];
        bus.tri_R16S       = t;
        bus.sample_R16S    = s;
        bus.color_R16U     = c;
        bus.cull_mode_R16U = cull_mode_e'(mm);
        bus.validSamp_R16H = 1'b1;
        #1;
        while (bus.readySamp_R16H !== 1'b1 && n < 200) begin
            saw_stall = 1;
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 200) begin
            n_test++;
            n_fail++;
            $display("FAIL send_timeout got=%0d exp<200", n);
        end
        @(posedge clk);
        #1;
        bus.validSamp_R16H = 1'b0;
    endtask

    task automatic do_reset();
        bus.validSamp_R16H = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        bus.hit_ready_R18H = 1'b1;
        repeat (PD + 4) tick();
    endtask

    task automatic test_reset();
        bus.tri_R16S       = '0;
        bus.sample_R16S    = '0;
        bus.color_R16U     = '0;
        bus.cull_mode_R16U = CULL_BACK;
        bus.validSamp_R16H = 1'b0;
        bus.hit_ready_R18H = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        mon_en = 1;
        n_test++;
        if (bus.hit_valid_R18H !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got=%b exp=0", bus.hit_valid_R18H);
        end
        n_test++;
        if (bus.samp_cnt_R18U !== '0 || bus.hit_cnt_R18U !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0",
                     bus.samp_cnt_R18U, bus.hit_cnt_R18U);
        end
        rst = 1'b0;
        #1;
        n_test++;
        if (bus.readySamp_R16H !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got=%b exp=1", bus.readySamp_R16H);
        end
        tick();
    endtask

    task automatic test_cw();
        vec_t e;
        do_reset();
        bus.hit_ready_R18H = 1'b1;
        send(mk_tri(0, 0, 77, 0, 4096, 4096, 0), mk_samp(1024, 1024), rcol(), 0);
        n_test++;
        if (bus.hit_valid_R18H !== 1'b0) begin
            n_fail++;
            $display("FAIL cw_early got=%b exp=0", bus.hit_valid_R18H);
        end
        tick();
        e = '0;
        e[0] = SF'(1024);
        e[1] = SF'(1024);
        e[2] = SF'(77);
        n_test++;
        if (bus.hit_valid_R18H !== 1'b1 || bus.hit_R18S !== e) begin
            n_fail++;
            $display("FAIL cw_latency got=%b/%h exp=1/%h",
                     bus.hit_valid_R18H, bus.hit_R18S, e);
        end
        tick();
        n_test++;
        if (bus.hit_cnt_R18U !== CW'(1) || bus.hit_valid_R18H !== 1'b0) begin
            n_fail++;
            $display("FAIL cw_cnt got=%0d/%b exp=1/0",
                     bus.hit_cnt_R18U, bus.hit_valid_R18H);
        end
    endtask

    task automatic test_cull();
        bit exp_hit[3];
        exp_hit = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            bus.hit_ready_R18H = 1'b1;
            send(mk_tri(0, 0, 5, 4096, 0, 0, 4096), mk_samp(1024, 1024), rcol(), k);
            drain();
            n_test++;
            if (bus.hit_cnt_R18U !== CW'(exp_hit[k]) || bus.samp_cnt_R18U !== CW'(1)) begin
                n_fail++;
                $display("FAIL cull_mode%0d got=%0d/%0d exp=%0d/1", k,
                         bus.hit_cnt_R18U, bus.samp_cnt_R18U, exp_hit[k]);
            end
        end
    endtask

    task automatic test_tie();
        tri_t  tt[8];
        samp_t ss[8];
        int    mm[8];
        bit    ee[8];
        tt[0] = mk_tri(0, 0, 1, 0, 4096, 4096, 0); ss[0] = mk_samp(0, 2048);
        mm[0] = 0; ee[0] = 1;
        tt[1] = tt[0]; ss[1] = mk_samp(2048, 2048); mm[1] = 0; ee[1] = 0;
        tt[2] = tt[0]; ss[2] = ss[1]; mm[2] = 2; ee[2] = 0;
        tt[3] = tt[0]; ss[3] = ss[1]; mm[3] = 1; ee[3] = 0;
        for (int k = 4; k < 8; k++) begin
            tt[k] = mk_tri(0, 0, 1, 0, 0, 0, 0);
            ss[k] = mk_samp(1024, 1024);
            mm[k] = k - 4;
            ee[k] = 0;
        end
        for (int k = 0; k < 8; k++) begin
            do_reset();
            bus.hit_ready_R18H = 1'b1;
            send(tt[k], ss[k], rcol(), mm[k]);
            drain();
            n_test++;
            if (bus.hit_cnt_R18U !== CW'(ee[k])) begin
                n_fail++;
                $display("FAIL tie_case%0d got=%0d exp=%0d", k, bus.hit_cnt_R18U, ee[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        saw_stall = 0;
        bus.hit_ready_R18H = 1'b1;
        fork
            begin
                repeat (3) tick();
                bus.hit_ready_R18H = 1'b0;
                repeat (5) tick();
                bus.hit_ready_R18H = 1'b1;
            end
            begin
                for (int i = 0; i < 10; i++)
                    send(mk_tri(0, 0, i, 0, 4096, 4096, 0),
                         mk_samp(64 + 100 * i, 64 + 50 * i), rcol(), 0);
            end
        join
        drain();
        n_test++;
        if (saw_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_drop got=%b exp=1", saw_stall);
        end
        n_test++;
        if (bus.hit_cnt_R18U !== CW'(10) || bus.samp_cnt_R18U !== CW'(10)) begin
            n_fail++;
            $display("FAIL bp_cnt got=%0d/%0d exp=10/10",
                     bus.hit_cnt_R18U, bus.samp_cnt_R18U);
        end
        n_test++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_lost got=%0d exp=0", q.size());
        end
    endtask

    task automatic test_bubble_reset();
        tri_t t;
        do_reset();
        t = mk_tri(0, 0, 3, 0, 4096, 4096, 0);
        bus.hit_ready_R18H = 1'b0;
        send(t, mk_samp(1024, 1024), rcol(), 0);
        send(t, mk_samp(3000, 3000), rcol(), 0);
        send(t, mk_samp(512, 512), rcol(), 0);
        n_test++;
        if (bus.samp_cnt_R18U !== CW'(3) || bus.hit_valid_R18H !== 1'b1
            || bus.readySamp_R16H !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_fill got=%0d/%b/%b exp=3/1/0", bus.samp_cnt_R18U,
                     bus.hit_valid_R18H, bus.readySamp_R16H);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.hit_ready_R18H = 1'b1;
        #1;
        n_test++;
        if (bus.readySamp_R16H !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready got=%b exp=1", bus.readySamp_R16H);
        end
        for (int k = 0; k < 4; k++) begin
            n_test++;
            if (bus.hit_valid_R18H !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_stale got=%b exp=0", bus.hit_valid_R18H);
            end
            tick();
        end
        n_test++;
        if (bus.samp_cnt_R18U !== '0 || bus.hit_cnt_R18U !== '0) begin
            n_fail++;
            $display("FAIL flush_cnt got=%0d/%0d exp=0/0",
                     bus.samp_cnt_R18U, bus.hit_cnt_R18U);
        end
    endtask

    task automatic test_saturation();
        tri_t t;
        do_reset();
        t = mk_tri(0, 0, 9, 0, 4096, 4096, 0);
        bus.hit_ready_R18H = 1'b1;
        for (int i = 0; i < 14; i++) send(t, mk_samp(100 + i, 200), rcol(), 0);
        drain();
        n_test++;
        if (bus.samp_cnt_R18U !== CW'(14) || bus.hit_cnt_R18U !== CW'(14)) begin
            n_fail++;
            $display("FAIL sat_pre got=%0d/%0d exp=14/14",
                     bus.samp_cnt_R18U, bus.hit_cnt_R18U);
        end
        for (int i = 0; i < 3; i++) send(t, mk_samp(300, 100 + i), rcol(), 0);
        drain();
        n_test++;
        if (bus.samp_cnt_R18U !== CW'(15) || bus.hit_cnt_R18U !== CW'(15)) begin
            n_fail++;
            $display("FAIL sat_end got=%0d/%0d exp=15/15",
                     bus.samp_cnt_R18U, bus.hit_cnt_R18U);
        end
    endtask

    task automatic test_random();
        do_reset();
        rnd_done = 0;
        fork
            begin
                while (!rnd_done) begin
                    bus.hit_ready_R18H = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
            begin
                for (int i = 0; i < 400; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(mk_tri(rcoord(), rcoord(), int'($urandom_range(0, 4095)),
                                rcoord(), rcoord(), rcoord(), rcoord()),
                         mk_samp(rcoord(), rcoord()), rcol(),
                         int'($urandom_range(0, 3)));
                end
                rnd_done = 1;
            end
        join
        drain();
        n_test++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_lost got=%0d exp=0", q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cw();
        test_cull();
        test_tie();
        test_backpressure();
        test_bubble_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
